mci_mcu_rst_arb: RTL



---
 rtl/mci_pkg.sv | 30 +++
 rtl/mci_mcu_rst_arb_if.sv | 56 +++++
 rtl/mci_mcu_rst_arb_rr.sv | 41 ++++
 rtl/mci_mcu_rst_arb.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mci_pkg.sv
// MCI shared types: boot sequencer states, MCU reset arbiter states and the
// default reset cool-down length.
package mci_pkg;

  // MCI boot sequencer state, observed by the MCU reset arbiter.
  typedef enum logic [3:0] {
    BOOT_IDLE             = 4'd0,
    BOOT_OTP_FC           = 4'd1,
    BOOT_I3C              = 4'd2,
    BOOT_MCU              = 4'd3,
    BOOT_WAIT_CPTRA_GO    = 4'd4,
    BOOT_CPTRA            = 4'd5,
    BOOT_WAIT_MCU_RST_REQ = 4'd6,
    BOOT_RST_MCU          = 4'd7,
    BOOT_RST_CPTRA        = 4'd8,
    BOOT_WAIT_CPTRA_RST   = 4'd9
  } mci_boot_fsm_state_e;

  // MCU reset arbiter state.
  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_ISSUE     = 3'd1,
    ARB_WAIT_EXIT = 3'd2,
    ARB_DONE      = 3'd3,
    ARB_COOLDOWN  = 3'd4
  } mci_mcu_rst_arb_state_e;

  localparam int unsigned MCI_MCU_RST_ARB_DEFAULT_COOLDOWN = 16;

endpackage

// File: rtl/mci_mcu_rst_arb_if.sv
// MCU reset arbiter bundle.
//   req          requester -> arbiter  level reset requests, one bit per source
//   boot_fsm     sequencer -> arbiter  current boot sequencer state
//   mcu_rst_req  arbiter -> sequencer  MCU reset request level
//   grant        arbiter -> requesters one-hot owner of the in-flight reset
//   done         arbiter -> requesters one-cycle completion pulse to the owner
//   grant_id     arbiter -> requesters index of the current/last owner
//   busy         arbiter -> requesters arbiter is not idle
//   timeout_err  arbiter -> requesters sticky completion timeout
//                (only when MCI_MCU_RST_ARB_TIMEOUT_EN is defined)
// Modports: master = arbiter side, slave = requester/sequencer side.
interface mci_mcu_rst_arb_if #(
  parameter int unsigned NUM_REQ = 4
);
  import mci_pkg::*;

  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]  req;
  mci_boot_fsm_state_e boot_fsm;
  logic                mcu_rst_req;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  done;
  logic [IdW-1:0]      grant_id;
  logic                busy;
`ifdef MCI_MCU_RST_ARB_TIMEOUT_EN
  logic                timeout_err;
`endif

  modport master (
    input  req,
    input  boot_fsm,
    output mcu_rst_req,
    output grant,
    output done,
    output grant_id,
    output busy
`ifdef MCI_MCU_RST_ARB_TIMEOUT_EN
    , output timeout_err
`endif
  );

  modport slave (
    output req,
    output boot_fsm,
    input  mcu_rst_req,
    input  grant,
    input  done,
    input  grant_id,
    input  busy
`ifdef MCI_MCU_RST_ARB_TIMEOUT_EN
    , input timeout_err
`endif
  );

endinterface

// File: rtl/mci_mcu_rst_arb_rr.sv
// Combinational round-robin arbiter.
//   req_i    request vector
//   ptr_i    index where the search starts (must be < NUM_REQ)
//   gnt_o    one-hot winner (zero if no request)
//   idx_o    winner index
//   valid_o  at least one request present
// The pointer register lives in the parent.
module mci_rr_arb #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       valid_o
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  int unsigned    pos;
  logic [IdW-1:0] pos_idx;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      pos = 32'(ptr_i) + off;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = IdW'(pos);
      if (!valid_o && req_i[pos_idx]) begin
        valid_o        = 1'b1;
        gnt_o[pos_idx] = 1'b1;
        idx_o          = pos_idx;
      end
    end
  end

endmodule

// File: rtl/mci_mcu_rst_arb.sv
// MCU reset arbiter: picks one of NUM_REQ reset requesters round-robin,
// drives mcu_rst_req to the MCI boot sequencer, follows the sequencer through
// the reset round-trip, pulses done to the owner and then enforces a
// cool-down before the next grant.
// Ports:
//   clk      MCI clock
//   mci_rst  asynchronous active-high reset
//   bus      mci_mcu_rst_arb_if.master (req/boot_fsm in; mcu_rst_req, grant,
//            done, grant_id, busy[, timeout_err] out)
// Optional feature macro: MCI_MCU_RST_ARB_TIMEOUT_EN adds a completion
// watchdog of TIMEOUT_CYCLES and the sticky timeout_err output.
module mci_mcu_rst_arb
  import mci_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned COOLDOWN_CYCLES = MCI_MCU_RST_ARB_DEFAULT_COOLDOWN,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic              clk,
  input  logic              mci_rst,
  mci_mcu_rst_arb_if.master bus
);

  localparam int unsigned IdW = $clog2(NUM_REQ);
  localparam int unsigned CdW = $clog2(COOLDOWN_CYCLES + 1);

  mci_mcu_rst_arb_state_e state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IdW-1:0]         grant_id_q, grant_id_d;
  logic [IdW-1:0]         ptr_q, ptr_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic [CdW-1:0]         cd_cnt_q, cd_cnt_d;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [IdW-1:0]         arb_idx;
  logic                   arb_valid;
  logic [NUM_REQ-1:0]     owner_oh;

`ifdef MCI_MCU_RST_ARB_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           terr_q, terr_d;
`endif

  mci_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arb (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign owner_oh = NUM_REQ'(1) << grant_id_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    done_d     = '0;
    cd_cnt_d   = cd_cnt_q;
`ifdef MCI_MCU_RST_ARB_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    terr_d     = terr_q;
`endif

    unique case (state_q)
      ARB_IDLE: begin
        // Only arbitrate while the sequencer is ready to accept a request.
        if (arb_valid && (bus.boot_fsm == BOOT_WAIT_MCU_RST_REQ)) begin
          grant_d    = arb_gnt;
          grant_id_d = arb_idx;
          ptr_d      = (arb_idx == IdW'(NUM_REQ - 1)) ? '0 : arb_idx + IdW'(1);
          state_d    = ARB_ISSUE;
`ifdef MCI_MCU_RST_ARB_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
        end
      end
      ARB_ISSUE: begin
        if (bus.boot_fsm == BOOT_RST_MCU) state_d = ARB_WAIT_EXIT;
      end
      ARB_WAIT_EXIT: begin
        // Done is registered so it lands while grant is already cleared and
        // the previous cycle still shows the owner.
        if (bus.boot_fsm == BOOT_WAIT_MCU_RST_REQ) begin
          state_d = ARB_DONE;
          done_d  = owner_oh;
          grant_d = '0;
        end
      end
      ARB_DONE: begin
        cd_cnt_d = CdW'(COOLDOWN_CYCLES - 1);
        state_d  = ARB_COOLDOWN;
      end
      ARB_COOLDOWN: begin
        if (cd_cnt_q == '0) state_d = ARB_IDLE;
        else                cd_cnt_d = cd_cnt_q - CdW'(1);
      end
      default: state_d = ARB_IDLE;
    endcase

`ifdef MCI_MCU_RST_ARB_TIMEOUT_EN
    // Watchdog overrides any normal transition in the same cycle.
    if ((state_q == ARB_ISSUE) || (state_q == ARB_WAIT_EXIT)) begin
      to_cnt_d = to_cnt_q + ToW'(1);
      if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
        terr_d   = 1'b1;
        done_d   = owner_oh;
        grant_d  = '0;
        cd_cnt_d = CdW'(COOLDOWN_CYCLES - 1);
        state_d  = ARB_COOLDOWN;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge mci_rst) begin
    if (mci_rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      done_q     <= '0;
      cd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      done_q     <= done_d;
      cd_cnt_q   <= cd_cnt_d;
    end
  end

`ifdef MCI_MCU_RST_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge mci_rst) begin
    if (mci_rst) begin
      to_cnt_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      terr_q   <= terr_d;
    end
  end

  assign bus.timeout_err = terr_q;
`endif

  // Request is a pure decode of state so it drops on the exit transition.
  assign bus.mcu_rst_req = (state_q == ARB_ISSUE);
  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = (state_q != ARB_IDLE);

  ParamsOk_A: assert property (@(posedge clk)
    (NUM_REQ >= 2) && (COOLDOWN_CYCLES >= 1) && (TIMEOUT_CYCLES >= 1));

  GrantOnehot0_A: assert property (@(posedge clk) disable iff (mci_rst)
    $onehot0(grant_q));

  DoneOnehot0_A: assert property (@(posedge clk) disable iff (mci_rst)
    $onehot0(done_q));

  DoneOwner_A: assert property (@(posedge clk) disable iff (mci_rst)
    (done_q != '0) |-> (done_q == $past(grant_q)));

  RstReqIssue_A: assert property (@(posedge clk) disable iff (mci_rst)
    bus.mcu_rst_req |-> (state_q == ARB_ISSUE));

  StateKnown_A: assert property (@(posedge clk) disable iff (mci_rst)
    !$isunknown(state_q));

endmodule
